// File: rtl/chan_mux_pipe.sv
// N-to-1 channel multiplexer with a one-word registered output stage.
// Round-robin arbitration and its pointer exist only when CHAN_MUX_PIPE_RR_EN is defined.
module chan_mux_pipe #(
    parameter int unsigned NCH = 8,
    parameter int unsigned W   = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               mode,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] sel,
    input  logic [NCH*W-1:0]                   in_data,
    input  logic [NCH-1:0]                     in_valid,
    output logic [NCH-1:0]                     in_ready,
    output logic [W-1:0]                       out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] grant
);

    localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [W-1:0]   r_out_data;
    logic           r_out_valid;
    logic [SW-1:0]  r_grant;

    logic           w_load_en;
    logic [SW-1:0]  w_fix_gnt;
    logic           w_fix_ok;
    logic [SW-1:0]  w_gnt;
    logic           w_gnt_ok;
    logic [NCH-1:0] w_ready;
    logic           w_xfer;
    logic [W-1:0]   w_sel_data;

    assign w_load_en = !r_out_valid | out_ready;

    // Fixed mode: an out-of-range select grants nothing
    assign w_fix_gnt = sel;
    assign w_fix_ok  = (32'(sel) < NCH);

`ifdef CHAN_MUX_PIPE_RR_EN
    logic [SW-1:0]  r_ptr;
    logic [SW-1:0]  w_rr_hi;
    logic           w_rr_hi_ok;
    logic [SW-1:0]  w_rr_lo;
    logic           w_rr_lo_ok;
    logic [SW-1:0]  w_ptr_nxt;

    // Round-robin search: lowest valid index at or above ptr, else lowest valid overall (wrap)
    always_comb begin
        w_rr_hi    = '0;
        w_rr_hi_ok = 1'b0;
        w_rr_lo    = '0;
        w_rr_lo_ok = 1'b0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                w_rr_lo    = SW'(k);
                w_rr_lo_ok = 1'b1;
                if (SW'(k) >= r_ptr) begin
                    w_rr_hi    = SW'(k);
                    w_rr_hi_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_gnt    = w_fix_gnt;
        w_gnt_ok = w_fix_ok;
        if (mode) begin
            w_gnt    = w_rr_hi_ok ? w_rr_hi : w_rr_lo;
            w_gnt_ok = w_rr_hi_ok | w_rr_lo_ok;
        end
    end

    assign w_ptr_nxt = ((32'(w_gnt) + 32'd1) >= NCH) ? '0 : (w_gnt + SW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (mode && w_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    logic w_mode_unused;
    assign w_mode_unused = mode;

    always_comb begin
        w_gnt    = w_fix_gnt;
        w_gnt_ok = w_fix_ok;
    end
`endif

    // One-hot ready toward the granted channel, gated by output-stage space
    always_comb begin
        w_ready = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            w_ready[k] = rst_n & w_gnt_ok & w_load_en & (w_gnt == SW'(k));
        end
    end

    assign w_xfer = |(in_valid & w_ready);

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (w_gnt == SW'(k)) begin
                w_sel_data = in_data[k*W +: W];
            end
        end
    end

    // Output stage: load on transfer, drop valid on consume, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_grant     <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_grant     <= w_gnt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign grant     = r_grant;

endmodule

// File: tb/tb_chan_mux_pipe.sv
// Directed self-checking bench for chan_mux_pipe (NCH=8 main instance, NCH=5 for out-of-range select).
module tb_chan_mux_pipe;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [2:0]  sel;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  grant;

    logic        mode5;
    logic [2:0]  sel5;
    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic [7:0]  out_data5;
    logic        out_valid5;
    logic        out_ready5;
    logic [2:0]  grant5;

    int total;
    int bad;

    chan_mux_pipe #(.NCH(8), .W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .grant(grant)
    );

    chan_mux_pipe #(.NCH(5), .W(8)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
        .grant(grant5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL reset_in_ready: got %h expected 00", in_ready); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        total++; if (grant !== 3'd0) begin bad++; $display("FAIL reset_grant: got %0d expected 0", grant); end
        total++; if (out_valid5 !== 1'b0) begin bad++; $display("FAIL reset_out_valid5: got %b expected 0", out_valid5); end
    endtask

    task automatic test_fixed_b2b();
        rst_n = 1'b1; mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 8'h20) begin bad++; $display("FAIL fixed_in_ready: got %h expected 20", in_ready); end
        step();
        total++; if (out_data !== 8'hA5 || grant !== 3'd5 || out_valid !== 1'b1) begin
            bad++; $display("FAIL fixed_first: got data=%h grant=%0d valid=%b expected A5/5/1", out_data, grant, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            in_data[5*8 +: 8] = 8'h50 + 8'(i);
            #1;
            total++; if (in_ready !== 8'h20) begin bad++; $display("FAIL b2b_ready[%0d]: got %h expected 20", i, in_ready); end
            step();
            total++; if (out_data !== (8'h50 + 8'(i)) || out_valid !== 1'b1) begin
                bad++; $display("FAIL b2b_word[%0d]: got data=%h valid=%b expected %h/1", i, out_data, out_valid, 8'h50 + 8'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_data[5*8 +: 8] = 8'h77;
        #1;
        total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL bp_in_ready: got %h expected 00", in_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (out_data !== 8'h53 || out_valid !== 1'b1 || grant !== 3'd5) begin
                bad++; $display("FAIL bp_hold[%0d]: got data=%h valid=%b grant=%0d expected 53/1/5", i, out_data, out_valid, grant);
            end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 8'h20) begin bad++; $display("FAIL bp_release_ready: got %h expected 20", in_ready); end
        step();
        total++; if (out_data !== 8'h77 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_release_word: got data=%h valid=%b expected 77/1", out_data, out_valid);
        end
        in_valid = 8'h00;
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h77 || grant !== 3'd5) begin
            bad++; $display("FAIL drain: got valid=%b data=%h grant=%0d expected 0/77/5", out_valid, out_data, grant);
        end
    endtask

    task automatic test_sel_change();
        sel = 3'd2; in_valid = 8'hFF;
        step();
        total++; if (out_data !== 8'hA2 || grant !== 3'd2) begin
            bad++; $display("FAIL sel_change: got data=%h grant=%0d expected A2/2", out_data, grant);
        end
    endtask

    task automatic test_out_of_range();
        sel5 = 3'd1; in_valid5 = 5'h1F; out_ready5 = 1'b0;
        step();
        total++; if (out_data5 !== 8'h11 || out_valid5 !== 1'b1 || grant5 !== 3'd1) begin
            bad++; $display("FAIL oor_load: got data=%h valid=%b grant=%0d expected 11/1/1", out_data5, out_valid5, grant5);
        end
        sel5 = 3'd6;
        #1;
        total++; if (in_ready5 !== 5'h00) begin bad++; $display("FAIL oor_ready_stalled: got %h expected 00", in_ready5); end
        step();
        total++; if (out_valid5 !== 1'b1 || out_data5 !== 8'h11) begin
            bad++; $display("FAIL oor_hold: got valid=%b data=%h expected 1/11", out_valid5, out_data5);
        end
        out_ready5 = 1'b1;
        #1;
        total++; if (in_ready5 !== 5'h00) begin bad++; $display("FAIL oor_ready_open: got %h expected 00", in_ready5); end
        step();
        total++; if (out_valid5 !== 1'b0) begin bad++; $display("FAIL oor_drain: got valid=%b expected 0", out_valid5); end
        step();
        total++; if (out_valid5 !== 1'b0 || in_ready5 !== 5'h00) begin
            bad++; $display("FAIL oor_idle: got valid=%b ready=%h expected 0/00", out_valid5, in_ready5);
        end
    endtask

    task automatic test_reset_midstall();
        sel = 3'd3; in_valid = 8'hFF; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA3) begin
            bad++; $display("FAIL stall_pre_reset: got valid=%b data=%h expected 1/A3", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL midreset_ready: got %h expected 00", in_ready); end
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || grant !== 3'd0) begin
            bad++; $display("FAIL midreset_clear: got valid=%b data=%h grant=%0d expected 0/00/0", out_valid, out_data, grant);
        end
        rst_n = 1'b1; mode = 1'b1; sel = 3'd7; in_valid = 8'h85; out_ready = 1'b1;
        step();
`ifdef CHAN_MUX_PIPE_RR_EN
        total++; if (grant !== 3'd0 || out_data !== 8'hA0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL post_reset_rr: got grant=%0d data=%h valid=%b expected 0/A0/1", grant, out_data, out_valid);
        end
`else
        total++; if (grant !== 3'd7 || out_data !== 8'hA7 || out_valid !== 1'b1) begin
            bad++; $display("FAIL mode_ignored: got grant=%0d data=%h valid=%b expected 7/A7/1", grant, out_data, out_valid);
        end
`endif
        mode = 1'b0;
    endtask

`ifdef CHAN_MUX_PIPE_RR_EN
    task automatic test_round_robin();
        logic [2:0] exp_g [6];
        exp_g = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2, 3'd7};
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; mode = 1'b1; in_valid = 8'b1000_0101; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (in_ready !== (8'h01 << exp_g[i])) begin
                bad++; $display("FAIL rr_ready[%0d]: got %h expected %h", i, in_ready, 8'h01 << exp_g[i]);
            end
            step();
            total++; if (grant !== exp_g[i] || out_valid !== 1'b1) begin
                bad++; $display("FAIL rr_grant[%0d]: got %0d valid=%b expected %0d/1", i, grant, out_valid, exp_g[i]);
            end
        end
        in_valid = 8'h00;
        #1;
        total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL rr_empty_ready: got %h expected 00", in_ready); end
        step();
        in_valid = 8'h84;
        step();
        total++; if (grant !== 3'd2) begin bad++; $display("FAIL rr_ptr_hold: got %0d expected 2", grant); end
        mode = 1'b0;
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; mode = 1'b0; sel = 3'd0; in_valid = 8'h00; out_ready = 1'b0;
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'hA0 | 8'(k);
        mode5 = 1'b0; sel5 = 3'd0; in_valid5 = 5'h00; out_ready5 = 1'b0;
        for (int k = 0; k < 5; k++) in_data5[k*8 +: 8] = 8'h10 | 8'(k);
        test_reset();
        test_fixed_b2b();
        test_backpressure();
        test_sel_change();
        test_out_of_range();
        test_reset_midstall();
`ifdef CHAN_MUX_PIPE_RR_EN
        test_round_robin();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
